// File: rtl/xctcmsg_pkg.sv
// Shared message types and default sizes for the message pipeline queues.
package xctcmsg_pkg;

    localparam int SEND_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] payload;
        logic [7:0]  opcode;
    } xctcmsg_t;

    // Message plus the passthrough tag carried alongside it to the postoffice.
    typedef struct packed {
        xctcmsg_t    msg;
        logic [7:0]  tag;
    } send_queue_data_t;

endpackage

// File: rtl/xctcmsg_fifo.sv
// Generic circular FIFO: storage array plus wrap-bit read/write pointers.
// Handshake gating lives in the wrappers; enq/deq here are already qualified.
module xctcmsg_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               enq,
    input  logic               deq,
    input  logic [DATA_W-1:0]  wr_data,
    output logic [DATA_W-1:0]  rd_data,
    output logic               empty,
    output logic               full,
    output logic [COUNT_W-1:0] count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [COUNT_W-1:0] rd_ptr;
    logic [COUNT_W-1:0] wr_ptr;

    // Pointer update; reset and flush both discard everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + COUNT_W'(1);
            if (deq) rd_ptr <= rd_ptr + COUNT_W'(1);
        end
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (enq && !rst && !flush) mem[wr_ptr[IDX_W-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[IDX_W-1:0]];
    assign empty   = (rd_ptr == wr_ptr);
    assign full    = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) &&
                     (rd_ptr[IDX_W] != wr_ptr[IDX_W]);
    assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/send_queue.sv
// Send queue between issue and postoffice: typed wrapper around the generic
// FIFO adding ready/valid gating. Ready may follow postoffice ready so a full
// queue can take an entry in the same cycle its head leaves.
module send_queue
    import xctcmsg_pkg::*;
#(
    parameter int DEPTH   = SEND_QUEUE_DEPTH,
    parameter int COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                issue_send_queue_valid,
    output logic                                send_queue_issue_ready,
    input  logic [$bits(send_queue_data_t)-1:0] issue_send_queue_data,
    output logic                                send_queue_postoffice_valid,
    input  logic                                postoffice_send_queue_ready,
    output logic [$bits(send_queue_data_t)-1:0] send_queue_postoffice_data,
    output logic [COUNT_W-1:0]                  send_queue_count,
    output logic                                send_queue_empty
);

    localparam int DATA_W = $bits(send_queue_data_t);

    logic block;
    logic enq;
    logic deq;
    logic full;
    logic empty;

    // Reset or flush hides the head and refuses new entries in the same cycle.
    assign block = rst | flush;

    assign send_queue_postoffice_valid = !empty && !block;
    assign deq                         = send_queue_postoffice_valid && postoffice_send_queue_ready;
    assign send_queue_issue_ready      = (!full || deq) && !block;
    assign enq                         = issue_send_queue_valid && send_queue_issue_ready;
    assign send_queue_empty            = empty;

    xctcmsg_fifo #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .enq     (enq),
        .deq     (deq),
        .wr_data (issue_send_queue_data),
        .rd_data (send_queue_postoffice_data),
        .empty   (empty),
        .full    (full),
        .count   (send_queue_count)
    );

    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        send_queue_count <= COUNT_W'(DEPTH));

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(enq && full && !deq));

    a_head_stable : assert property (@(posedge clk) disable iff (rst || flush)
        (send_queue_postoffice_valid && !postoffice_send_queue_ready)
        |=> $stable(send_queue_postoffice_data));

endmodule

// File: tb/tb_send_queue.sv
// Bench for send_queue: directed vector table plus randomized traffic, all
// checked against a queue-based reference model.
module tb_send_queue;
    import xctcmsg_pkg::*;

    localparam int DEPTH   = 4;
    localparam int COUNT_W = 3;
    localparam int DW      = $bits(send_queue_data_t);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DW-1:0]      in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DW-1:0]      out_data;
    logic [COUNT_W-1:0] count;
    logic               empty;

    always #5 clk = ~clk;

    send_queue #(.DEPTH(DEPTH)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .flush                       (flush),
        .issue_send_queue_valid      (in_valid),
        .send_queue_issue_ready      (in_ready),
        .issue_send_queue_data       (in_data),
        .send_queue_postoffice_valid (out_valid),
        .postoffice_send_queue_ready (out_ready),
        .send_queue_postoffice_data  (out_data),
        .send_queue_count            (count),
        .send_queue_empty            (empty)
    );

    int checks = 0;
    int errors = 0;

    send_queue_data_t model_q[$];

    logic               s_ready, s_valid, s_empty;
    logic [COUNT_W-1:0] s_count;
    logic [DW-1:0]      s_data;

    typedef struct {
        logic        r, f, iv;
        logic [15:0] addr;
        logic        pr;
        logic        e_ready, e_valid;
        int          e_count;   // -1: not checked (reset cycle)
        logic        e_empty;
        logic [15:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic send_queue_data_t mk(input logic [15:0] a);
        send_queue_data_t d;
        d.msg.addr    = a;
        d.msg.payload = {a, ~a};
        d.msg.opcode  = a[7:0] ^ 8'h5a;
        d.tag         = a[15:8] + 8'h33;
        return d;
    endfunction

    function automatic vec_t v(input logic r, f, iv, input logic [15:0] addr, input logic pr,
                               input logic er, ev, input int ec, input logic ee,
                               input logic [15:0] ea);
        vec_t x;
        x.r = r; x.f = f; x.iv = iv; x.addr = addr; x.pr = pr;
        x.e_ready = er; x.e_valid = ev; x.e_count = ec; x.e_empty = ee; x.e_addr = ea;
        return x;
    endfunction

    // One clock cycle: drive, sample mid-cycle, compare with model, advance model.
    task automatic step(input logic r, input logic f, input logic iv,
                        input send_queue_data_t d, input logic pr);
        logic m_valid, m_deq, m_ready;
        @(posedge clk);
        #1;
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = pr;
        @(negedge clk);
        s_ready = in_ready; s_valid = out_valid; s_count = count;
        s_empty = empty;    s_data  = out_data;
        m_valid = !r && !f && (model_q.size() > 0);
        m_deq   = m_valid && pr;
        m_ready = !r && !f && ((model_q.size() < DEPTH) || m_deq);
        chk("model_issue_ready", 64'(s_ready), 64'(m_ready));
        chk("model_po_valid", 64'(s_valid), 64'(m_valid));
        if (!r) begin
            chk("model_count", 64'(s_count), 64'(model_q.size()));
            chk("model_empty", 64'(s_empty), 64'(model_q.size() == 0));
        end
        if (m_valid) chk("model_head_data", 64'(s_data), 64'(model_q[0]));
        if (r || f) begin
            model_q.delete();
        end else begin
            if (m_deq) void'(model_q.pop_front());
            if (iv && m_ready) model_q.push_back(d);
        end
    endtask

    initial begin
        // reset, then three enqueues held at the output, then drain
        tbl.push_back(v(1,0,0,16'h0000,0, 0,0,-1,1,16'h0000));
        tbl.push_back(v(0,0,1,16'h0001,0, 1,0, 0,1,16'h0000));
        tbl.push_back(v(0,0,1,16'h0002,0, 1,1, 1,0,16'h0001));
        tbl.push_back(v(0,0,1,16'h0003,0, 1,1, 2,0,16'h0001));
        tbl.push_back(v(0,0,0,16'h0000,0, 1,1, 3,0,16'h0001));
        tbl.push_back(v(0,0,0,16'h0000,0, 1,1, 3,0,16'h0001));
        tbl.push_back(v(0,0,0,16'h0000,1, 1,1, 3,0,16'h0001));
        tbl.push_back(v(0,0,0,16'h0000,1, 1,1, 2,0,16'h0002));
        tbl.push_back(v(0,0,0,16'h0000,1, 1,1, 1,0,16'h0003));
        tbl.push_back(v(0,0,0,16'h0000,0, 1,0, 0,1,16'h0000));
        // fill to DEPTH, then enqueue and dequeue together while full
        tbl.push_back(v(0,0,1,16'h0010,0, 1,0, 0,1,16'h0000));
        tbl.push_back(v(0,0,1,16'h0011,0, 1,1, 1,0,16'h0010));
        tbl.push_back(v(0,0,1,16'h0012,0, 1,1, 2,0,16'h0010));
        tbl.push_back(v(0,0,1,16'h0013,0, 1,1, 3,0,16'h0010));
        tbl.push_back(v(0,0,1,16'h0014,0, 0,1, 4,0,16'h0010));
        tbl.push_back(v(0,0,1,16'h0014,1, 1,1, 4,0,16'h0010));
        tbl.push_back(v(0,0,0,16'h0000,0, 0,1, 4,0,16'h0011));
        // flush with two entries, an enqueue and postoffice ready all at once
        tbl.push_back(v(1,0,0,16'h0000,0, 0,0,-1,1,16'h0000));
        tbl.push_back(v(0,0,1,16'h0020,0, 1,0, 0,1,16'h0000));
        tbl.push_back(v(0,0,1,16'h0021,0, 1,1, 1,0,16'h0020));
        tbl.push_back(v(0,1,1,16'h0022,1, 0,0, 2,0,16'h0000));
        tbl.push_back(v(0,0,0,16'h0000,1, 1,0, 0,1,16'h0000));
        // fill, reset while full, then one fresh entry must come out intact
        tbl.push_back(v(0,0,1,16'h0030,0, 1,0, 0,1,16'h0000));
        tbl.push_back(v(0,0,1,16'h0031,0, 1,1, 1,0,16'h0030));
        tbl.push_back(v(0,0,1,16'h0032,0, 1,1, 2,0,16'h0030));
        tbl.push_back(v(0,0,1,16'h0033,0, 1,1, 3,0,16'h0030));
        tbl.push_back(v(1,0,0,16'h0000,0, 0,0,-1,1,16'h0000));
        tbl.push_back(v(0,0,1,16'h0040,0, 1,0, 0,1,16'h0000));
        tbl.push_back(v(0,0,0,16'h0000,1, 1,1, 1,0,16'h0040));
        tbl.push_back(v(0,0,0,16'h0000,1, 1,0, 0,1,16'h0000));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].f, tbl[i].iv, mk(tbl[i].addr), tbl[i].pr);
            chk($sformatf("tbl%0d_issue_ready", i), 64'(s_ready), 64'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_po_valid", i), 64'(s_valid), 64'(tbl[i].e_valid));
            if (tbl[i].e_count >= 0) begin
                chk($sformatf("tbl%0d_count", i), 64'(s_count), 64'(tbl[i].e_count));
                chk($sformatf("tbl%0d_empty", i), 64'(s_empty), 64'(tbl[i].e_empty));
            end
            if (tbl[i].e_valid)
                chk($sformatf("tbl%0d_head", i), 64'(s_data), 64'(mk(tbl[i].e_addr)));
        end

        // randomized traffic with rare flush/reset; many pointer wraps
        for (int n = 0; n < 600; n++) begin
            logic r, f, iv, pr;
            send_queue_data_t d;
            r  = ($urandom_range(0, 119) == 0);
            f  = ($urandom_range(0, 59) == 0);
            iv = ($urandom_range(0, 2) != 0);
            pr = ($urandom_range(0, 2) != 0);
            d  = send_queue_data_t'({$urandom(), $urandom()});
            step(r, f, iv, d, pr);
        end

        // drain whatever is left
        for (int n = 0; n < DEPTH + 2; n++) step(0, 0, 0, mk(16'h0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
